// File: rtl/seg7_display_pkg.sv
// Shared constants for the seven-segment display driver: active-low segment
// patterns {g,f,e,d,c,b,a}, the "all off" values and the scan phase type.
package seg7_pkg;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   typedef enum logic {
      DEAD = 1'b0,
      SHOW = 1'b1
   } phase_e;

endpackage

// File: rtl/seg7_display_decode.sv
// Hex nibble to active-low seven-segment pattern, purely combinational.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      unique case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg7_display.sv
// Eight-digit multiplexed hex display driver: frame-aligned snapshot of the
// core data bus, scan prescaler, anti-ghosting dead time, registered outputs.
module seg7_display
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned DEAD_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_i,
   input  logic        hold_i,
   input  logic        blank_i,
   input  logic [7:0]  dp_mask_i,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o
);

   localparam int unsigned CNT_W     = $clog2(SCAN_DIV);
   localparam int unsigned DEAD_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
   localparam int unsigned DEAD_LOAD = (DEAD_CYC == 0) ? 0 : DEAD_CYC - 1;
   localparam logic [2:0]  IDX_LAST  = 3'(DIGITS - 1);

   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        idx_q, idx_d;
   logic [DEAD_W-1:0] dead_q, dead_d;
   phase_e            phase_q, phase_d;
   logic [31:0]       shown_q, shown_d;
   logic              tick;
   logic [3:0]        nibble;
   logic [6:0]        dec_seg;
   logic              blank_dig;

   assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));

   // Outputs are registered from next-state values so that the pins follow
   // the phase in the same cycle it is entered. The dead counter is therefore
   // loaded one short, keeping DEAD visible for max(DEAD_CYC,1) cycles.
   always_comb begin
      idx_d   = idx_q;
      dead_d  = dead_q;
      phase_d = phase_q;
      shown_d = shown_q;
      if (tick) begin
         idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 3'd1;
         phase_d = DEAD;
         dead_d  = DEAD_W'(DEAD_LOAD);
         if (idx_q == IDX_LAST && !hold_i)
            shown_d = data_i;
      end else if (phase_q == DEAD) begin
         if (dead_q == '0)
            phase_d = SHOW;
         else
            dead_d = dead_q - 1'b1;
      end
   end

   assign nibble    = shown_d[{idx_d, 2'b00} +: 4];
   assign blank_dig = blank_i && (idx_d != '0) && ((shown_d >> {idx_d, 2'b00}) == '0);

   seg7_decode u_decode (
      .nibble (nibble),
      .seg    (dec_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= IDX_LAST;
         dead_q  <= DEAD_W'(DEAD_LOAD);
         phase_q <= DEAD;
         shown_q <= '0;
         an_o    <= AN_OFF;
         seg_o   <= SEG_OFF;
         dp_o    <= 1'b1;
      end else begin
         cnt_q   <= tick ? '0 : cnt_q + 1'b1;
         idx_q   <= idx_d;
         dead_q  <= dead_d;
         phase_q <= phase_d;
         shown_q <= shown_d;
         if (phase_d == SHOW) begin
            an_o  <= ~(8'd1 << idx_d);
            seg_o <= blank_dig ? SEG_OFF : dec_seg;
            dp_o  <= ~dp_mask_i[idx_d];
         end else begin
            an_o  <= AN_OFF;
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_display.sv
// Scoreboard bench for seg7_display: two instances (DEAD_CYC=1 and 0) share
// stimulus; a timing/arithmetic reference model predicts every output cycle.
module tb_seg7_display;

   localparam int unsigned SCAN = 4;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   localparam exp_t DARK = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
   localparam logic [6:0] SEGTAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data_i = '0;
   logic        hold_i = 1'b0;
   logic        blank_i = 1'b0;
   logic [7:0]  dp_mask_i = '0;
   logic [7:0]  an1, an0;
   logic [6:0]  seg1, seg0;
   logic        dp1, dp0;

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned cyc    = 0;
   logic [31:0] m_shown = '0;
   logic        mon_en = 1'b0;
   exp_t        q1[$];
   exp_t        q0[$];

   always #5 clk = ~clk;

   seg7_display #(.DIGITS(8), .SCAN_DIV(SCAN), .DEAD_CYC(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .hold_i(hold_i),
      .blank_i(blank_i), .dp_mask_i(dp_mask_i),
      .an_o(an1), .seg_o(seg1), .dp_o(dp1));

   seg7_display #(.DIGITS(8), .SCAN_DIV(SCAN), .DEAD_CYC(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .hold_i(hold_i),
      .blank_i(blank_i), .dp_mask_i(dp_mask_i),
      .an_o(an0), .seg_o(seg0), .dp_o(dp0));

   // Reset behaves like a tick at cycle -1 selecting digit 7; slot k starts
   // at cycle k*SCAN and is dark for max(dead,1) cycles.
   function automatic exp_t model_out(input int unsigned c, input logic [31:0] sh,
                                      input logic b, input logic [7:0] m,
                                      input int unsigned dead);
      exp_t        e;
      int unsigned dig, off, dl;
      logic [31:0] upper;
      dig = (c / SCAN + 7) % 8;
      off = c % SCAN;
      dl  = (dead == 0) ? 1 : dead;
      if (off < dl) return DARK;
      upper = sh >> (4 * dig);
      e.an  = ~(8'd1 << dig);
      e.seg = (b && dig != 0 && upper == 0) ? 7'h7F : SEGTAB[upper[3:0]];
      e.dp  = ~m[dig];
      return e;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s cycle %0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                    name, cyc, act.an, act.seg, act.dp, exp.an, exp.seg, exp.dp);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (q1.size() > 0) check("dead1", {an1, seg1, dp1}, q1.pop_front());
         if (q0.size() > 0) check("dead0", {an0, seg0, dp0}, q0.pop_front());
      end
   end

   // Called at posedge+1 with rst_n low: this cycle becomes cycle 0.
   task automatic do_release();
      rst_n   = 1'b1;
      cyc     = 0;
      m_shown = '0;
      q1.delete();
      q0.delete();
      q1.push_back(DARK);
      q0.push_back(DARK);
      mon_en  = 1'b1;
   endtask

   task automatic step(input logic [31:0] d, input logic h, input logic b, input logic [7:0] m);
      data_i = d; hold_i = h; blank_i = b; dp_mask_i = m;
      if (cyc % SCAN == SCAN - 1 && (cyc / SCAN) % 8 == 0 && !h) m_shown = d;
      q1.push_back(model_out(cyc + 1, m_shown, b, m, 1));
      q0.push_back(model_out(cyc + 1, m_shown, b, m, 0));
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int unsigned n, input logic [31:0] d, input logic h,
                      input logic b, input logic [7:0] m);
      for (int unsigned i = 0; i < n; i++) step(d, h, b, m);
   endtask

   task automatic run_random(input int unsigned n);
      logic [31:0] d;
      d = $urandom;
      for (int unsigned i = 0; i < n; i++) begin
         if ($urandom_range(0, 5) == 0) d = $urandom >> (4 * $urandom_range(0, 7));
         step(d, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 8'($urandom));
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset1", {an1, seg1, dp1}, DARK);
      check("reset0", {an0, seg0, dp0}, DARK);
      do_release();

      run(40, 32'h12345678, 1'b0, 1'b0, 8'h00);
      run(64, 32'h000000A0, 1'b0, 1'b1, 8'h00);
      run(64, 32'h000000A0, 1'b0, 1'b0, 8'h00);
      run(40, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00);
      run(96, 32'h00000000, 1'b1, 1'b0, 8'h00);
      run(64, 32'h00000000, 1'b0, 1'b0, 8'h00);
      run(40, 32'h12345678, 1'b0, 1'b1, 8'h04);
      run_random(400);

      // asynchronous reset in the middle of a SHOW slot
      while (!(cyc >= SCAN && cyc % SCAN == 2)) run_random(1);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst1", {an1, seg1, dp1}, DARK);
      check("async_rst0", {an0, seg0, dp0}, DARK);
      @(posedge clk);
      #1;
      do_release();
      run_random(200);

      @(posedge clk);
      #1;
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
